// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the CDB writeback arbiter slice.
// TOPC_NONE marks "no redirect" (pc+4) and is also the value the ROB expects.
package cdb_arbiter_pkg;
    localparam int          ROB_SIZE_LOG_DEF = 4;
    localparam int          SRC_W            = 2;
    localparam logic [31:0] TOPC_NONE        = 32'hFFFF_FFFF;

    function automatic logic [SRC_W-1:0] rr_next(input logic [SRC_W-1:0] idx, input int n);
        int nx;
        nx = int'(idx) + 1;
        if (nx >= n) nx = 0;
        return SRC_W'(nx);
    endfunction
endpackage

// File: rtl/cdb_fifo.sv
// Per-producer result queue; push/pop gated by rdy, full and empty.
// Data storage is not reset, only the pointers and the occupancy count.
module cdb_fifo #(
    parameter int W     = 68,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rdy,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic          do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = rdy && push && !full;
    assign do_pop  = rdy && pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the registered CDB broadcast lane among N_REQ
// producers, each buffered by a private cdb_fifo. Flush behaves exactly like rst.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int N_REQ        = 3,
    parameter int QDEPTH       = 2,
    parameter int ROB_SIZE_LOG = ROB_SIZE_LOG_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rdy,
    input  logic                        flush,
    input  logic [N_REQ-1:0]            req_valid,
    output logic [N_REQ-1:0]            req_ready,
    input  logic [N_REQ*ROB_SIZE_LOG-1:0] req_robid,
    input  logic [N_REQ*32-1:0]         req_value,
    input  logic [N_REQ*32-1:0]         req_topc,
    output logic                        cdb_valid,
    output logic [ROB_SIZE_LOG-1:0]     cdb_robid,
    output logic [31:0]                 cdb_value,
    output logic [31:0]                 cdb_topc,
    output logic [SRC_W-1:0]            cdb_src
);
    localparam int RW = ROB_SIZE_LOG;
    localparam int EW = RW + 64;

    logic                       clr;
    logic [N_REQ-1:0][EW-1:0]   head;
    logic [N_REQ-1:0]           empty, full, gnt_oh;
    logic [SRC_W-1:0]           rr_ptr, gnt_idx;
    logic                       gnt_any;
    logic [EW-1:0]              win;
    int                         pos;

    assign clr       = rst | flush;
    assign req_ready = ~full;

    for (genvar g = 0; g < N_REQ; g++) begin : g_q
        cdb_fifo #(.W(EW), .DEPTH(QDEPTH)) u_fifo (
            .clk   (clk),
            .rst   (clr),
            .rdy   (rdy),
            .push  (req_valid[g]),
            .din   ({req_robid[g*RW +: RW], req_value[g*32 +: 32], req_topc[g*32 +: 32]}),
            .pop   (gnt_oh[g]),
            .dout  (head[g]),
            .empty (empty[g]),
            .full  (full[g])
        );
    end

    // Rotating priority: first non-empty queue starting at rr_ptr wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        gnt_oh  = '0;
        win     = '0;
        pos     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            pos = int'(rr_ptr) + k;
            if (pos >= N_REQ) pos = pos - N_REQ;
            for (int i = 0; i < N_REQ; i++) begin
                if (!gnt_any && i == pos && !empty[i]) begin
                    gnt_any   = 1'b1;
                    gnt_idx   = SRC_W'(i);
                    gnt_oh[i] = 1'b1;
                end
            end
        end
        for (int i = 0; i < N_REQ; i++)
            win = win | (head[i] & {EW{gnt_oh[i]}});
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            rr_ptr    <= '0;
            cdb_valid <= 1'b0;
            cdb_robid <= '0;
            cdb_value <= '0;
            cdb_topc  <= TOPC_NONE;
            cdb_src   <= '0;
        end else if (rdy) begin
            if (gnt_any) begin
                cdb_valid                        <= 1'b1;
                {cdb_robid, cdb_value, cdb_topc} <= win;
                cdb_src                          <= gnt_idx;
                rr_ptr                           <= rr_next(gnt_idx, N_REQ);
            end else begin
                cdb_valid <= 1'b0;
            end
        end
    end
endmodule
